ctrl_pipeline_unit: RTL

Parametrised successor to the combinational Controller. It registers the fetched instruction into ID and decodes it with the same field encodings (`ALU_*`, `BRU_*`, memOp from Constants.vh). It then carries the EX/MEM/WB control bundles through pipeline registers with valid bits. It adds load-use hazard detection with a configurable bubble count, branch flush and a global freeze, and it flags illegal opcodes. It sits between fetch and the datapath stage registers.

---
 rtl/ctrl_pipeline_unit_if.sv | 55 +++++
 rtl/ctrl_pipeline_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline_unit_if.sv
// ---------------------------------------------------------------------------
// ctrl_pipeline_unit_if
// Bundles the fetch handshake, the pipeline steering inputs and the EX/MEM/WB
// control outputs of ctrl_pipeline_unit.
//   master : fetch/steering side (drives if_valid, if_instr, stall_i, flush_i)
//   slave  : ctrl_pipeline_unit (drives id_ready_o and all *_o bundles)
// Signals:
//   if_valid/if_instr/id_ready_o      fetch -> ID handshake
//   stall_i                           global freeze
//   flush_i                           branch/jump redirect resolved in EX
//   ex_valid_o/ex_ctrl_o/ex_rd_o      {jalr, bruOp[2:0], aluOp[3:0], aluSrc[1:0]}
//   mem_valid_o/mem_ctrl_o/mem_rd_o   {memOp[2:0], memWr, memRd}
//   wb_valid_o/wb_ctrl_o/wb_rd_o      {regWr, memToReg}
//   illegal_o                         one-cycle pulse after an illegal op enters WB
// ---------------------------------------------------------------------------
interface ctrl_pipeline_unit_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int RW = $clog2(NREG);

  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic            id_ready_o;
  logic            stall_i;
  logic            flush_i;
  logic            ex_valid_o;
  logic [9:0]      ex_ctrl_o;
  logic [RW-1:0]   ex_rd_o;
  logic            mem_valid_o;
  logic [4:0]      mem_ctrl_o;
  logic [RW-1:0]   mem_rd_o;
  logic            wb_valid_o;
  logic [1:0]      wb_ctrl_o;
  logic [RW-1:0]   wb_rd_o;
  logic            illegal_o;

  modport master (
    output if_valid, if_instr, stall_i, flush_i,
    input  id_ready_o,
    input  ex_valid_o, ex_ctrl_o, ex_rd_o,
    input  mem_valid_o, mem_ctrl_o, mem_rd_o,
    input  wb_valid_o, wb_ctrl_o, wb_rd_o,
    input  illegal_o
  );

  modport slave (
    input  if_valid, if_instr, stall_i, flush_i,
    output id_ready_o,
    output ex_valid_o, ex_ctrl_o, ex_rd_o,
    output mem_valid_o, mem_ctrl_o, mem_rd_o,
    output wb_valid_o, wb_ctrl_o, wb_rd_o,
    output illegal_o
  );
endinterface

// File: rtl/ctrl_pipeline_unit.sv
// ---------------------------------------------------------------------------
// ctrl_pipeline_unit
// Pipelined RV32I control unit: registers the fetched instruction into ID,
// decodes it, and carries the EX/MEM/WB control bundles through valid-tagged
// stage registers. Handles load-use hazards (configurable bubble count),
// branch flush, global freeze and illegal-opcode reporting.
// Ports:
//   clk   clock
//   rstN  asynchronous active-low reset
//   bus   ctrl_pipeline_unit_if.slave (fetch handshake, steering, stage bundles)
// Encodings:
//   aluOp : ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 LUI=10
//   bruOp : NONE=0 EQ=1 NE=2 LT=3 GE=4 LTU=5 GEU=6 JAL=7
//   aluSrc: bit1 selects PC as operand A, bit0 selects immediate as operand B
//   memOp : load/store funct3 (0 for non-memory ops)
// ---------------------------------------------------------------------------
module ctrl_pipeline_unit #(
  parameter int XLEN             = 32,
  parameter int NREG             = 32,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input logic                clk,
  input logic                rstN,
  ctrl_pipeline_unit_if.slave bus
);
  localparam int RW = $clog2(NREG);
  localparam logic [1:0] BUBBLE_RELOAD = 2'(LOAD_USE_BUBBLES - 1);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  localparam logic [2:0] BRU_NONE = 3'd0;
  localparam logic [2:0] BRU_EQ   = 3'd1;
  localparam logic [2:0] BRU_NE   = 3'd2;
  localparam logic [2:0] BRU_LT   = 3'd3;
  localparam logic [2:0] BRU_GE   = 3'd4;
  localparam logic [2:0] BRU_LTU  = 3'd5;
  localparam logic [2:0] BRU_GEU  = 3'd6;
  localparam logic [2:0] BRU_JAL  = 3'd7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic       jalr;
    logic [2:0] bru;
    logic [3:0] alu;
    logic [1:0] src;
    logic [2:0] mem_op;
    logic       mem_wr;
    logic       mem_rd;
    logic       reg_wr;
    logic       mem_to_reg;
    logic       illegal;
    logic       use_rs1;
    logic       use_rs2;
  } dec_t;

  // funct3 -> ALU op; alt (instr[30]) picks SUB only for R-type, SRA for both
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt,
                                         input logic is_r);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Branch funct3 -> BRU op; reserved codes compare nothing
  function automatic logic [2:0] bru_sel(input logic [2:0] f3);
    logic [2:0] op;
    case (f3)
      3'b000:  op = BRU_EQ;
      3'b001:  op = BRU_NE;
      3'b100:  op = BRU_LT;
      3'b101:  op = BRU_GE;
      3'b110:  op = BRU_LTU;
      3'b111:  op = BRU_GEU;
      default: op = BRU_NONE;
    endcase
    return op;
  endfunction

  // Full control truth table; unknown opcodes give all-zero controls + illegal
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d = '0;
    case (instr[6:0])
      OP_R: begin
        d.alu = alu_sel(instr[14:12], instr[30], 1'b1);
        d.reg_wr = 1'b1; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
      end
      OP_IMM: begin
        d.alu = alu_sel(instr[14:12], instr[30], 1'b0);
        d.src = 2'b01; d.reg_wr = 1'b1; d.use_rs1 = 1'b1;
      end
      OP_LOAD: begin
        d.alu = ALU_ADD; d.src = 2'b01; d.mem_op = instr[14:12]; d.mem_rd = 1'b1;
        d.reg_wr = 1'b1; d.mem_to_reg = 1'b1; d.use_rs1 = 1'b1;
      end
      OP_STORE: begin
        d.alu = ALU_ADD; d.src = 2'b01; d.mem_op = instr[14:12]; d.mem_wr = 1'b1;
        d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        d.alu = ALU_SUB; d.bru = bru_sel(instr[14:12]);
        d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
      end
      OP_LUI: begin
        d.alu = ALU_LUI; d.src = 2'b01; d.reg_wr = 1'b1;
      end
      OP_AUIPC: begin
        d.alu = ALU_ADD; d.src = 2'b11; d.reg_wr = 1'b1;
      end
      OP_JAL: begin
        d.alu = ALU_ADD; d.src = 2'b11; d.bru = BRU_JAL; d.reg_wr = 1'b1;
      end
      OP_JALR: begin
        d.alu = ALU_ADD; d.src = 2'b01; d.jalr = 1'b1; d.reg_wr = 1'b1;
        d.use_rs1 = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  // ID stage and hazard counter
  logic          id_valid_r;
  logic [31:0]   id_instr_r;
  logic [1:0]    cnt_r;
  // EX stage
  logic          ex_valid_r;
  logic [9:0]    ex_ctrl_r;
  logic [RW-1:0] ex_rd_r;
  logic [4:0]    ex_mem_r;
  logic [1:0]    ex_wb_r;
  logic          ex_ill_r;
  // MEM stage
  logic          mem_valid_r;
  logic [4:0]    mem_ctrl_r;
  logic [RW-1:0] mem_rd_r;
  logic [1:0]    mem_wb_r;
  logic          mem_ill_r;
  // WB stage
  logic          wb_valid_r;
  logic [1:0]    wb_ctrl_r;
  logic [RW-1:0] wb_rd_r;
  logic          wb_ill_r;
  logic          wb_fresh_r;
  logic          illegal_r;

  dec_t          dec_s;
  logic [RW-1:0] rd_s, rs1_s, rs2_s;
  logic          hazard_now_s;
  logic          id_valid_nxt_s;
  logic [31:0]   id_instr_nxt_s;
  logic [1:0]    cnt_nxt_s;
  logic          ex_valid_nxt_s;
  logic [9:0]    ex_ctrl_nxt_s;
  logic [RW-1:0] ex_rd_nxt_s;
  logic [4:0]    ex_mem_nxt_s;
  logic [1:0]    ex_wb_nxt_s;
  logic          ex_ill_nxt_s;

  // Decode the ID register and detect a load-use dependency on the EX load
  always_comb begin
    dec_s  = decode(id_instr_r);
    rd_s   = RW'(id_instr_r[11:7]);
    rs1_s  = RW'(id_instr_r[19:15]);
    rs2_s  = RW'(id_instr_r[24:20]);
    hazard_now_s = ex_valid_r && ex_mem_r[0] && (ex_rd_r != '0) && id_valid_r &&
                   ((dec_s.use_rs1 && (rs1_s == ex_rd_r)) ||
                    (dec_s.use_rs2 && (rs2_s == ex_rd_r)));
  end

  // Next ID/EX/counter contents for a non-stalled edge: flush > counter > hazard > advance
  always_comb begin
    id_valid_nxt_s = id_valid_r;
    id_instr_nxt_s = id_instr_r;
    cnt_nxt_s      = cnt_r;
    ex_valid_nxt_s = 1'b0;
    ex_ctrl_nxt_s  = 10'd0;
    ex_rd_nxt_s    = '0;
    ex_mem_nxt_s   = 5'd0;
    ex_wb_nxt_s    = 2'd0;
    ex_ill_nxt_s   = 1'b0;
    if (bus.flush_i) begin
      id_valid_nxt_s = 1'b0;
      id_instr_nxt_s = 32'd0;
      cnt_nxt_s      = 2'd0;
    end else if (cnt_r != 2'd0) begin
      cnt_nxt_s = cnt_r - 2'd1;
    end else if (hazard_now_s) begin
      cnt_nxt_s = BUBBLE_RELOAD;
    end else begin
      if (id_valid_r) begin
        ex_valid_nxt_s = 1'b1;
        ex_ctrl_nxt_s  = {dec_s.jalr, dec_s.bru, dec_s.alu, dec_s.src};
        ex_rd_nxt_s    = dec_s.reg_wr ? rd_s : '0;
        ex_mem_nxt_s   = {dec_s.mem_op, dec_s.mem_wr, dec_s.mem_rd};
        ex_wb_nxt_s    = {dec_s.reg_wr, dec_s.mem_to_reg};
        ex_ill_nxt_s   = dec_s.illegal;
      end else begin
        ex_valid_nxt_s = 1'b0;
      end
      if (bus.if_valid) begin
        id_valid_nxt_s = 1'b1;
        id_instr_nxt_s = bus.if_instr[31:0];
      end else begin
        id_valid_nxt_s = 1'b0;
        id_instr_nxt_s = 32'd0;
      end
    end
  end

  // Stage registers; stall freezes everything including the counter
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      id_valid_r  <= 1'b0;  id_instr_r <= 32'd0;  cnt_r <= 2'd0;
      ex_valid_r  <= 1'b0;  ex_ctrl_r  <= 10'd0;  ex_rd_r  <= '0;
      ex_mem_r    <= 5'd0;  ex_wb_r    <= 2'd0;   ex_ill_r <= 1'b0;
      mem_valid_r <= 1'b0;  mem_ctrl_r <= 5'd0;   mem_rd_r <= '0;
      mem_wb_r    <= 2'd0;  mem_ill_r  <= 1'b0;
      wb_valid_r  <= 1'b0;  wb_ctrl_r  <= 2'd0;   wb_rd_r  <= '0;
      wb_ill_r    <= 1'b0;
    end else if (!bus.stall_i) begin
      id_valid_r  <= id_valid_nxt_s;  id_instr_r <= id_instr_nxt_s;  cnt_r <= cnt_nxt_s;
      ex_valid_r  <= ex_valid_nxt_s;  ex_ctrl_r  <= ex_ctrl_nxt_s;   ex_rd_r  <= ex_rd_nxt_s;
      ex_mem_r    <= ex_mem_nxt_s;    ex_wb_r    <= ex_wb_nxt_s;     ex_ill_r <= ex_ill_nxt_s;
      mem_valid_r <= ex_valid_r;      mem_ctrl_r <= ex_mem_r;        mem_rd_r <= ex_rd_r;
      mem_wb_r    <= ex_wb_r;         mem_ill_r  <= ex_ill_r;
      wb_valid_r  <= mem_valid_r;     wb_ctrl_r  <= mem_wb_r;        wb_rd_r  <= mem_rd_r;
      wb_ill_r    <= mem_ill_r;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // One-shot illegal report: only the edge right after WB was loaded may fire it
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wb_fresh_r <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      wb_fresh_r <= !bus.stall_i;
      illegal_r  <= wb_fresh_r && wb_valid_r && wb_ill_r;
    end
  end

  assign bus.id_ready_o  = !bus.stall_i && (cnt_r == 2'd0) && !hazard_now_s;
  assign bus.ex_valid_o  = ex_valid_r;
  assign bus.ex_ctrl_o   = ex_ctrl_r;
  assign bus.ex_rd_o     = ex_rd_r;
  assign bus.mem_valid_o = mem_valid_r;
  assign bus.mem_ctrl_o  = mem_ctrl_r;
  assign bus.mem_rd_o    = mem_rd_r;
  assign bus.wb_valid_o  = wb_valid_r;
  assign bus.wb_ctrl_o   = wb_ctrl_r;
  assign bus.wb_rd_o     = wb_rd_r;
  assign bus.illegal_o   = illegal_r;
endmodule
